imem_load_arbiter: RTL and testbench
====================================

Name: imem_load_arbiter

Overview:
- Owns the single-port instruction memory.
- After reset it holds the core in stall and streams a program image into memory over a valid/ready loader port.
- After the image is loaded it releases the core and arbitrates the shared memory port between CPU instruction fetch and runtime patch writes.
- Fetch has priority; a starvation counter guarantees the loader forward progress.

Parameters:
- DEPTH_WORDS, 128, instruction memory depth in 32-bit words (power of two)
- STARVE_MAX, 8, consecutive cycles a pending patch write may be blocked by fetch before it is forced through
- NOP_WORD, 32'h00000013, instruction returned on a non-granted or invalid fetch (addi x0,x0,0)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- ld_valid  in  1  loader word valid
- ld_ready  out  1  loader word accepted this cycle when ld_valid high
- ld_addr  in  32  loader byte address
- ld_data  in  32  loader instruction word
- ld_last  in  1  marks final word of the boot image
- fetch_req  in  1  CPU fetch request
- fetch_addr  in  32  CPU PC (byte address)
- fetch_gnt  out  1  fetch served this cycle
- fetch_data  out  32  instruction to core
- mem_we  out  1  memory write enable
- mem_addr  out  log2(DEPTH_WORDS)  word index to memory
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory combinational read data
- core_hold  out  1  stalls the core (PC frozen) while high
- load_done  out  1  boot image complete
- words_loaded  out  16  count of boot words accepted
- err_addr  out  1  sticky: misaligned or out-of-range address seen

Behaviour:
- Reset: state=LOAD, core_hold=1, load_done=0, words_loaded=0, err_addr=0, starvation counter=0. Memory contents are not cleared by this block.
- Reset mid-operation behaves identically: any in-flight loader beat is dropped.
- Word index is addr[log2(DEPTH_WORDS)+1:2].
- An address is invalid if addr[1:0]!=0 or addr>=4*DEPTH_WORDS.
- State LOAD:
  - ld_ready=1; fetch_gnt=0; fetch_data=NOP_WORD; core_hold=1.
  - On ld_valid: mem_we=1 the same cycle with mem_addr and mem_wdata from the loader, and words_loaded increments at the next edge.
  - Invalid loader address: the beat is accepted, mem_we=0, err_addr set, and the beat still counts toward words_loaded.
  - words_loaded saturates at 16'hFFFF.
  - Accepted beat with ld_last=1 -> DRAIN.
- State DRAIN (1 cycle): ld_ready=0; mem_we=0. Next state RUN.
- State RUN:
  - core_hold=0; load_done=1.
  - Grant rule, evaluated combinationally each cycle:
    - force = ld_valid && (starve_cnt==STARVE_MAX).
    - Loader granted if ld_valid && (!fetch_req || force).
    - Otherwise fetch granted if fetch_req.
  - Fetch grant: fetch_gnt=1, mem_addr=fetch index, mem_we=0, fetch_data=mem_rdata (zero-cycle latency).
  - Invalid fetch address: fetch_gnt=1, fetch_data=NOP_WORD, err_addr set.
  - Loader grant: ld_ready=1; mem_we=1 if the address is valid; fetch_gnt=0; fetch_data=NOP_WORD; core_hold=1 for that cycle only, so the PC does not advance.
  - starve_cnt:
    - increments at the edge when ld_valid && !ld_ready;
    - clears when the loader is granted or ld_valid=0;
    - saturates at STARVE_MAX.
  - ld_last is ignored in RUN; words_loaded does not change.
- Simultaneous fetch_req and ld_valid with force=0: fetch wins, ld_ready=0, and the loader must hold its data stable.
- Idle memory port: mem_addr=0, mem_we=0.
- No write-through bypass: a fetch of the word written in the same cycle is not possible because the port is single-access.

Decomposition:
- Shared package (imem_pkg):
  - state enum {LOAD, DRAIN, RUN};
  - NOP_WORD constant;
  - IMEM_DEPTH default;
  - word-index function.
- One natural sub-module, imem_starve_ctr: the saturating starvation counter with its force output.
- FSM and grant muxing stay in the top module.

Test Plan:
- Reset, then load 3 words at 0x0, 0x4, 0x8 with ld_last on the third -> three mem_we pulses at indices 0,1,2; words_loaded=3; core_hold falls 2 cycles after the last beat; load_done=1.
- RUN, fetch_req held with fetch_addr=0x4, mem_rdata=0x01988 6B3 (add x13,x17,x25) -> fetch_gnt=1, fetch_data=0x019886B3, mem_addr=1.
- RUN, fetch_req every cycle plus ld_valid patch at 0x2C (data 0x00948663) -> ld_ready low for 8 cycles, then one cycle with ld_ready=1, mem_we=1, mem_addr=11, core_hold=1, fetch_data=0x00000013.
- Loader beat at 0x6 (misaligned) during LOAD -> no mem_we, err_addr=1 and sticky, words_loaded increments.
- Fetch at 0x200 (out of range for 128 words) -> fetch_data=0x00000013, err_addr=1.
- Assert rst mid-load after 2 of 5 beats -> words_loaded=0, state LOAD, core_hold=1, ld_ready=1 after release.

Source files
------------

// File: rtl/imem_load_arbiter_pkg.sv
// Shared types, defaults and address helpers for the instruction-memory
// boot loader / fetch arbiter.
package imem_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    localparam logic [31:0] IMEM_NOP        = 32'h0000_0013;  // addi x0,x0,0
    localparam int          IMEM_DEPTH      = 128;
    localparam int          IMEM_STARVE_MAX = 8;

    // Word index of a byte address; callers size-cast to their index width.
    function automatic logic [31:0] word_idx(input logic [31:0] addr);
        return addr >> 2;
    endfunction

    function automatic logic addr_valid(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] == 2'b00) && (addr < (32'(depth) << 2));
    endfunction

endpackage

// File: rtl/imem_load_arbiter_if.sv
// Loader, fetch, memory and status signals of the instruction-memory arbiter.
interface imem_load_arbiter_if #(
    parameter int DEPTH_WORDS = 128
) ();
    localparam int AW = $clog2(DEPTH_WORDS);

    logic          ld_valid;
    logic          ld_ready;
    logic [31:0]   ld_addr;
    logic [31:0]   ld_data;
    logic          ld_last;
    logic          fetch_req;
    logic [31:0]   fetch_addr;
    logic          fetch_gnt;
    logic [31:0]   fetch_data;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          core_hold;
    logic          load_done;
    logic [15:0]   words_loaded;
    logic          err_addr;

    modport slave (
        input  ld_valid, ld_addr, ld_data, ld_last, fetch_req, fetch_addr, mem_rdata,
        output ld_ready, fetch_gnt, fetch_data, mem_we, mem_addr, mem_wdata,
               core_hold, load_done, words_loaded, err_addr
    );

    modport master (
        output ld_valid, ld_addr, ld_data, ld_last, fetch_req, fetch_addr, mem_rdata,
        input  ld_ready, fetch_gnt, fetch_data, mem_we, mem_addr, mem_wdata,
               core_hold, load_done, words_loaded, err_addr
    );

endinterface

// File: rtl/imem_load_arbiter_starve_ctr.sv
// Counts consecutive cycles a pending patch write is refused; once it reaches
// STARVE_MAX the loader is forced ahead of fetch.
module imem_starve_ctr
    import imem_pkg::*;
#(
    parameter int STARVE_MAX = IMEM_STARVE_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic ld_valid_i,
    input  logic ld_ready_i,
    output logic force_o
);
    localparam int            CW      = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        if (!ld_valid_i || ld_ready_i) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses <= so all flops sample pre-edge values together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_o = ld_valid_i && (cnt_q == CNT_MAX);

endmodule

// File: rtl/imem_load_arbiter.sv
// Boot-image loader and fetch/patch arbiter for the single-port instruction
// memory; the core is held until the image is in.
module imem_load_arbiter
    import imem_pkg::*;
#(
    parameter int          DEPTH_WORDS = IMEM_DEPTH,
    parameter int          STARVE_MAX  = IMEM_STARVE_MAX,
    parameter logic [31:0] NOP_WORD    = IMEM_NOP
) (
    input logic                clk,
    input logic                rst,
    imem_load_arbiter_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    state_e        state_q;
    logic [15:0]   words_q;
    logic          err_q;
    logic          load_done_q;

    logic          ld_ok;
    logic          fetch_ok;
    logic [AW-1:0] ld_idx;
    logic [AW-1:0] fetch_idx;
    logic          force_ld;
    logic          ld_take;
    logic          fetch_take;

    assign ld_ok     = addr_valid(bus.ld_addr, DEPTH_WORDS);
    assign fetch_ok  = addr_valid(bus.fetch_addr, DEPTH_WORDS);
    assign ld_idx    = AW'(word_idx(bus.ld_addr));
    assign fetch_idx = AW'(word_idx(bus.fetch_addr));

    imem_starve_ctr #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve (
        .clk       (clk),
        .rst       (rst),
        .ld_valid_i(bus.ld_valid),
        .ld_ready_i(bus.ld_ready),
        .force_o   (force_ld)
    );

    always_comb begin
        ld_take        = 1'b0;
        fetch_take     = 1'b0;
        bus.ld_ready   = 1'b0;
        bus.fetch_gnt  = 1'b0;
        bus.fetch_data = NOP_WORD;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.core_hold  = 1'b1;
        unique case (state_q)
            ST_LOAD: begin
                bus.ld_ready = 1'b1;
                ld_take      = bus.ld_valid;
            end
            ST_RUN: begin
                bus.core_hold = 1'b0;
                if (bus.ld_valid && (!bus.fetch_req || force_ld)) begin
                    ld_take       = 1'b1;
                    bus.ld_ready  = 1'b1;
                    bus.core_hold = 1'b1;  // freeze the PC for the stolen cycle
                end else if (bus.fetch_req) begin
                    fetch_take    = 1'b1;
                    bus.fetch_gnt = 1'b1;
                    if (fetch_ok) begin
                        bus.mem_addr   = fetch_idx;
                        bus.fetch_data = bus.mem_rdata;
                    end
                end
            end
            default: ;
        endcase
        if (ld_take && ld_ok) begin
            bus.mem_we    = 1'b1;
            bus.mem_addr  = ld_idx;
            bus.mem_wdata = bus.ld_data;
        end
    end

    // NOTE: the memory array lives outside this block and keeps its contents across reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            words_q     <= '0;
            err_q       <= 1'b0;
            load_done_q <= 1'b0;
        end else begin
            if ((ld_take && !ld_ok) || (fetch_take && !fetch_ok)) begin
                err_q <= 1'b1;
            end
            unique case (state_q)
                ST_LOAD: begin
                    if (ld_take) begin
                        if (words_q != 16'hFFFF) begin
                            words_q <= words_q + 16'd1;
                        end
                        if (bus.ld_last) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    state_q     <= ST_RUN;
                    load_done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.words_loaded = words_q;
    assign bus.err_addr     = err_q;
    assign bus.load_done    = load_done_q;

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Self-checking bench: directed boot/patch/error steps plus randomized traffic
// against a cycle-level behavioural model of the loader and arbiter rules.
module tb_imem_load_arbiter;
    import imem_pkg::*;

    localparam int          DEPTH = 128;
    localparam int          SMAX  = 8;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_load_arbiter_if #(.DEPTH_WORDS(DEPTH)) bus ();

    imem_load_arbiter #(
        .DEPTH_WORDS(DEPTH),
        .STARVE_MAX (SMAX),
        .NOP_WORD   (NOP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Bench-side memory written by the DUT's write port.
    logic [31:0] tb_mem [DEPTH];
    assign bus.mem_rdata = tb_mem[bus.mem_addr];

    // Reference model state.
    logic [31:0] ref_mem [DEPTH];
    int          m_phase;  // 0 loading, 1 draining, 2 running
    int unsigned m_words;
    bit          m_err;
    int          m_starve;
    bit          m_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit ok_addr(input logic [31:0] a);
        return (a % 4 == 0) && (a < 4 * DEPTH);
    endfunction

    task automatic model_reset();
        m_phase  = 0;
        m_words  = 0;
        m_err    = 0;
        m_starve = 0;
        m_done   = 0;
    endtask

    // One clock: check outputs against the rules, then advance model and memory.
    task automatic cycle(output bit accepted);
        bit          ld_ok, f_ok, ld_go, f_go, frc;
        logic        e_ready, e_gnt, e_we, e_hold;
        logic [31:0] e_fdata, e_maddr;
        logic        s_we;
        logic [6:0]  s_addr;
        logic [31:0] s_wdata;
        #1;
        ld_ok   = ok_addr(bus.ld_addr);
        f_ok    = ok_addr(bus.fetch_addr);
        ld_go   = 0;
        f_go    = 0;
        e_ready = 0;
        e_gnt   = 0;
        e_we    = 0;
        e_hold  = 1;
        e_fdata = NOP;
        e_maddr = 0;
        if (m_phase == 0) begin
            e_ready = 1;
            ld_go   = bus.ld_valid;
        end else if (m_phase == 2) begin
            e_hold = 0;
            frc    = bus.ld_valid && (m_starve == SMAX);
            if (bus.ld_valid && (!bus.fetch_req || frc)) ld_go = 1;
            else if (bus.fetch_req) f_go = 1;
            if (ld_go) begin
                e_ready = 1;
                e_hold  = 1;
            end
            if (f_go) begin
                e_gnt = 1;
                if (f_ok) begin
                    e_maddr = bus.fetch_addr / 4;
                    e_fdata = ref_mem[int'(bus.fetch_addr / 4)];
                end
            end
        end
        if (ld_go && ld_ok) begin
            e_we    = 1;
            e_maddr = bus.ld_addr / 4;
        end
        check($sformatf("c%0d ld_ready", cyc), 32'(bus.ld_ready), 32'(e_ready));
        check($sformatf("c%0d fetch_gnt", cyc), 32'(bus.fetch_gnt), 32'(e_gnt));
        check($sformatf("c%0d fetch_data", cyc), bus.fetch_data, e_fdata);
        check($sformatf("c%0d mem_we", cyc), 32'(bus.mem_we), 32'(e_we));
        check($sformatf("c%0d mem_addr", cyc), 32'(bus.mem_addr), e_maddr);
        if (e_we) check($sformatf("c%0d mem_wdata", cyc), bus.mem_wdata, bus.ld_data);
        check($sformatf("c%0d core_hold", cyc), 32'(bus.core_hold), 32'(e_hold));
        check($sformatf("c%0d load_done", cyc), 32'(bus.load_done), 32'(m_done));
        check($sformatf("c%0d words_loaded", cyc), 32'(bus.words_loaded), m_words);
        check($sformatf("c%0d err_addr", cyc), 32'(bus.err_addr), 32'(m_err));
        s_we    = bus.mem_we;
        s_addr  = bus.mem_addr;
        s_wdata = bus.mem_wdata;
        @(posedge clk);
        if (s_we) tb_mem[s_addr] = s_wdata;
        if (ld_go && ld_ok) ref_mem[int'(bus.ld_addr / 4)] = bus.ld_data;
        if ((ld_go && !ld_ok) || (f_go && !f_ok)) m_err = 1;
        if (bus.ld_valid && !e_ready) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
        else m_starve = 0;
        if (m_phase == 0) begin
            if (ld_go) begin
                if (m_words < 16'hFFFF) m_words++;
                if (bus.ld_last) m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
            m_done  = 1;
        end
        accepted = ld_go;
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.ld_valid   = 0;
        bus.ld_addr    = 0;
        bus.ld_data    = 0;
        bus.ld_last    = 0;
        bus.fetch_req  = 0;
        bus.fetch_addr = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        model_reset();
        #1;
        check("rst core_hold", 32'(bus.core_hold), 32'd1);
        check("rst ld_ready", 32'(bus.ld_ready), 32'd1);
        check("rst load_done", 32'(bus.load_done), 32'd0);
        check("rst words_loaded", 32'(bus.words_loaded), 32'd0);
        check("rst err_addr", 32'(bus.err_addr), 32'd0);
        @(negedge clk);
        rst = 0;
    endtask

    task automatic load_beat(input logic [31:0] a, input logic [31:0] d, input bit last);
        bit acc;
        bus.ld_valid = 1;
        bus.ld_addr  = a;
        bus.ld_data  = d;
        bus.ld_last  = last;
        cycle(acc);
        bus.ld_valid = 0;
        bus.ld_last  = 0;
    endtask

    initial begin
        bit acc;
        bit pend;
        int blocked;
        for (int i = 0; i < DEPTH; i++) begin
            tb_mem[i]  = 32'h0;
            ref_mem[i] = 32'h0;
        end
        rst = 1;
        idle_inputs();
        @(negedge clk);
        do_reset();

        // Boot image of three words, then DRAIN and release.
        load_beat(32'h0, 32'h0000_0093, 0);
        load_beat(32'h4, 32'h0198_86B3, 0);
        load_beat(32'h8, 32'h0010_0113, 1);
        check("boot words", 32'(bus.words_loaded), 32'd3);
        cycle(acc);
        check("drain hold", 32'(bus.core_hold), 32'd0);
        check("boot done", 32'(bus.load_done), 32'd1);

        // Plain fetch.
        bus.fetch_req  = 1;
        bus.fetch_addr = 32'h4;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("fetch4 data", bus.fetch_data, 32'h0198_86B3);
            check("fetch4 idx", 32'(bus.mem_addr), 32'd1);
            cycle(acc);
        end

        // Patch write starved by continuous fetch, then forced through.
        bus.ld_valid = 1;
        bus.ld_addr  = 32'h2C;
        bus.ld_data  = 32'h0094_8663;
        blocked = 0;
        acc = 0;
        for (int k = 0; k < 20 && !acc; k++) begin
            cycle(acc);
            if (!acc) blocked++;
        end
        check("patch blocked cycles", 32'(blocked), 32'd8);
        bus.ld_valid = 0;
        bus.fetch_addr = 32'h2C;
        #1;
        check("patch readback", bus.fetch_data, 32'h0094_8663);
        cycle(acc);

        // Out-of-range fetch.
        check("err before oor", 32'(bus.err_addr), 32'd0);
        bus.fetch_addr = 32'h200;
        #1;
        check("oor fetch data", bus.fetch_data, NOP);
        cycle(acc);
        check("oor err", 32'(bus.err_addr), 32'd1);
        bus.fetch_req = 0;
        cycle(acc);

        // Misaligned loader beat during LOAD.
        do_reset();
        load_beat(32'h6, 32'hDEAD_BEEF, 0);
        check("misalign err", 32'(bus.err_addr), 32'd1);
        check("misalign words", 32'(bus.words_loaded), 32'd1);
        load_beat(32'h10, 32'h1234_5678, 0);
        check("misalign sticky", 32'(bus.err_addr), 32'd1);
        check("words after 2", 32'(bus.words_loaded), 32'd2);

        // Reset in the middle of a five-beat load.
        do_reset();
        load_beat(32'h0, 32'hAAAA_0001, 0);
        load_beat(32'h4, 32'hAAAA_0002, 0);
        bus.ld_valid = 1;
        bus.ld_addr  = 32'h8;
        bus.ld_data  = 32'hAAAA_0003;
        do_reset();
        check("midrst words", 32'(bus.words_loaded), 32'd0);
        cycle(acc);

        // Randomized boots and runtime traffic.
        for (int r = 0; r < 4; r++) begin
            int n;
            do_reset();
            n = 3 + int'($urandom % 6);
            for (int i = 0; i < n; i++) begin
                logic [31:0] a;
                if ($urandom % 3 == 0) cycle(acc);
                a = ($urandom % 8 == 0) ? $urandom : (($urandom % DEPTH) << 2);
                load_beat(a, $urandom, i == n - 1);
            end
            pend = 0;
            for (int c = 0; c < 150; c++) begin
                if (!pend && ($urandom % 3 == 0)) begin
                    pend = 1;
                    bus.ld_addr = ($urandom % 10 == 0) ? $urandom : (($urandom % DEPTH) << 2);
                    bus.ld_data = $urandom;
                    bus.ld_last = 1'($urandom);
                end
                bus.ld_valid   = pend;
                bus.fetch_req  = ($urandom % 4 != 0);
                bus.fetch_addr = ($urandom % 16 == 0) ? $urandom : (($urandom % DEPTH) << 2);
                cycle(acc);
                if (acc) pend = 0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
